// File: rtl/keypad_pkg.sv
// Shared types and key-code helpers for the 4x4 keypad scanner.
// Row r is strobed on bit (3-r); column c returns on bit c.
package keypad_pkg;

  localparam int KP_W = 4;

  typedef enum logic [2:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_REPORT,
    ST_HOLD,
    ST_RELEASE
  } kp_state_e;

  localparam logic [KP_W-1:0]   ROW_FIRST = 4'b1000;
  localparam logic [2*KP_W-1:0] KEY_NONE  = '0;

  function automatic logic is_onehot(input logic [KP_W-1:0] v);
    return (v != '0) && ((v & (v - {{(KP_W-1){1'b0}}, 1'b1})) == '0);
  endfunction

  // Row 3 (bit 0) wraps back to row 0 (bit 3).
  function automatic logic [KP_W-1:0] next_row(input logic [KP_W-1:0] r);
    return {r[0], r[KP_W-1:1]};
  endfunction

  function automatic logic [2*KP_W-1:0] key_code(input logic [KP_W-1:0] row,
                                                 input logic [KP_W-1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the asynchronous column returns.
module keypad_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner_4x4.sv
// 4x4 matrix keypad scanner: row strobe, debounced press/release, and a
// valid/ready key handshake. One key is tracked at a time, no auto-repeat.
//
//   state       | meaning
//   ------------+---------------------------------------------------------
//   ST_SCAN     | rotating rows, looking for a single-column return
//   ST_DEBOUNCE | row frozen, counting samples that match the candidate
//   ST_REPORT   | key_valid high, waiting for key_ready
//   ST_HOLD     | key consumed, row frozen, waiting for an all-zero sample
//   ST_RELEASE  | counting consecutive all-zero samples
module keypad_scanner_4x4
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic [KP_W-1:0]   row_drive,
  input  logic [KP_W-1:0]   col_sense,
  output logic [2*KP_W-1:0] key_data,
  output logic              key_valid,
  input  logic              key_ready,
  output logic              key_held
);

  localparam int DW  = $clog2(SCAN_DIV);
  localparam int CW  = $clog2(DEBOUNCE_CNT + 1);
  localparam int CW1 = CW + 1;

  kp_state_e          state, state_n;
  logic [DW-1:0]      dwell;
  logic [CW-1:0]      cnt, cnt_n, cnt_inc;
  logic [2*KP_W-1:0]  cand, cand_n, data_n;
  logic [KP_W-1:0]    row_n, col_s;
  logic               valid_n, held_n;
  logic               sample, cnt_hit;

  keypad_sync #(.W(KP_W)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (col_sense),
    .q   (col_s)
  );

  assign sample  = (dwell == DW'(SCAN_DIV - 1));
  assign cnt_inc = cnt + CW'(1);
  // True when this sample is the one that completes the debounce run.
  assign cnt_hit = ({1'b0, cnt} + CW1'(1)) >= CW1'(DEBOUNCE_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_SCAN;
      dwell     <= '0;
      cnt       <= '0;
      cand      <= KEY_NONE;
      row_drive <= ROW_FIRST;
      key_data  <= KEY_NONE;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_n;
      dwell     <= sample ? '0 : dwell + DW'(1);
      cnt       <= cnt_n;
      cand      <= cand_n;
      row_drive <= row_n;
      key_data  <= data_n;
      key_valid <= valid_n;
      key_held  <= held_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cand_n  = cand;
    row_n   = row_drive;
    data_n  = key_data;
    valid_n = key_valid;
    held_n  = key_held;

    case (state)
      ST_SCAN: begin
        if (sample) begin
          if (is_onehot(col_s)) begin
            if (cnt_hit) begin
              data_n  = key_code(row_drive, col_s);
              valid_n = 1'b1;
              held_n  = 1'b1;
              cnt_n   = '0;
              state_n = ST_REPORT;
            end else begin
              cand_n  = key_code(row_drive, col_s);
              cnt_n   = cnt_inc;
              state_n = ST_DEBOUNCE;
            end
          end else begin
            row_n = next_row(row_drive);
          end
        end
      end

      ST_DEBOUNCE: begin
        if (sample) begin
          if (key_code(row_drive, col_s) == cand) begin
            if (cnt_hit) begin
              data_n  = cand;
              valid_n = 1'b1;
              held_n  = 1'b1;
              cnt_n   = '0;
              state_n = ST_REPORT;
            end else begin
              cnt_n = cnt_inc;
            end
          end else begin
            cnt_n   = '0;
            cand_n  = KEY_NONE;
            row_n   = next_row(row_drive);
            state_n = ST_SCAN;
          end
        end
      end

      // Samples are ignored here so a quick release cannot retract the key.
      ST_REPORT: begin
        if (key_valid && key_ready) begin
          valid_n = 1'b0;
          state_n = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (sample && (col_s == '0)) begin
          if (cnt_hit) begin
            held_n  = 1'b0;
            cnt_n   = '0;
            row_n   = next_row(row_drive);
            state_n = ST_SCAN;
          end else begin
            cnt_n   = cnt_inc;
            state_n = ST_RELEASE;
          end
        end
      end

      ST_RELEASE: begin
        if (sample) begin
          if (col_s == '0) begin
            if (cnt_hit) begin
              held_n  = 1'b0;
              cnt_n   = '0;
              row_n   = next_row(row_drive);
              state_n = ST_SCAN;
            end else begin
              cnt_n = cnt_inc;
            end
          end else begin
            cnt_n   = '0;
            state_n = ST_HOLD;
          end
        end
      end

      default: state_n = ST_SCAN;
    endcase
  end

endmodule

// File: tb/tb_keypad_scanner_4x4.sv
// Bench for keypad_scanner_4x4: a keypad stand-in drives col_sense from
// row_drive, and a sample-level model predicts every output each cycle.
module tb_keypad_scanner_4x4;

  localparam int SD = 4;
  localparam int DB = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_drive;
  logic [3:0] col_sense;
  logic [7:0] key_data;
  logic       key_valid;
  logic       key_ready = 1'b1;
  logic       key_held;

  int   mode = 0;   // 0 open, 1 single key, 2 bouncing row 3, 3 ghost on row 0
  int   pr = 0, pc = 0;
  logic bounce_val = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  keypad_scanner_4x4 #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
    .clk       (clk),
    .rst       (rst),
    .row_drive (row_drive),
    .col_sense (col_sense),
    .key_data  (key_data),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_held  (key_held)
  );

  always_comb begin
    col_sense = 4'b0000;
    case (mode)
      1: if (row_drive == (4'b1000 >> pr)) col_sense = 4'b0001 << pc;
      2: if (row_drive == 4'b0001) col_sense = {3'b000, bounce_val};
      3: if (row_drive == 4'b1000) col_sense = 4'b0011;
      default: col_sense = 4'b0000;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- behavioural model ----------------
  int         m_t, m_row, m_streak, m_zeros;
  logic [7:0] m_cand, m_data, m_code;
  logic [3:0] m_s1, m_s2, m_smp;
  bit         m_valid, m_held, m_take, m_match;
  bit         m_init = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_t = 0; m_row = 0; m_streak = 0; m_zeros = 0;
      m_cand = 8'h00; m_data = 8'h00;
      m_valid = 1'b0; m_held = 1'b0;
      m_s1 = 4'h0; m_s2 = 4'h0;
      m_init = 1'b1;
    end else begin
      m_smp  = m_s2;
      m_take = ((m_t % SD) == SD - 1);
      m_code = {4'b1000 >> m_row, m_smp};
      if (m_valid) begin
        if (key_ready) m_valid = 1'b0;
      end else if (m_held) begin
        if (m_take) begin
          if (m_smp == 4'h0) begin
            m_zeros++;
            if (m_zeros == DB) begin
              m_held = 1'b0; m_zeros = 0; m_row = (m_row + 1) % 4;
            end
          end else begin
            m_zeros = 0;
          end
        end
      end else if (m_take) begin
        m_match = (m_streak == 0) ? ($countones(m_smp) == 1) : (m_code == m_cand);
        if (m_match) begin
          if (m_streak == 0) m_cand = m_code;
          m_streak++;
          if (m_streak == DB) begin
            m_data = m_cand; m_valid = 1'b1; m_held = 1'b1; m_streak = 0;
          end
        end else begin
          m_streak = 0; m_row = (m_row + 1) % 4;
        end
      end
      m_t++;
      m_s2 = m_s1;
      m_s1 = col_sense;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      check("row_drive", 32'(row_drive), 32'(4'b1000 >> m_row));
      check("key_valid", 32'(key_valid), 32'(m_valid));
      check("key_held",  32'(key_held),  32'(m_held));
      check("key_data",  32'(key_data),  32'(m_data));
    end
  end

  // ---------------- directed scenarios ----------------
  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!key_valid && n < 300) begin tick(1); n++; end
    check({name, "_valid_seen"}, 32'(key_valid), 32'd1);
  endtask

  task automatic wait_release(input string name);
    int n;
    n = 0;
    while (key_held && n < 300) begin tick(1); n++; end
    check({name, "_held_drop"}, 32'(key_held), 32'd0);
  endtask

  task automatic run_quiet(input int n, output int nv, output int rows_seen);
    nv = 0; rows_seen = 0;
    for (int i = 0; i < n; i++) begin
      if (mode == 2 && (i % 4) == 0) bounce_val = ~bounce_val;
      tick(1);
      if (key_valid) nv++;
      rows_seen |= int'(row_drive);
    end
  endtask

  initial begin
    int nv, rows, k;
    bit stable;

    tick(3);
    rst = 1'b0;
    check("rst_row", 32'(row_drive), 32'h8);
    check("rst_valid", 32'(key_valid), 32'd0);
    check("rst_held", 32'(key_held), 32'd0);
    check("rst_data", 32'(key_data), 32'h00);

    // Idle scan: 4 cycles per row, rows 8,4,2,1,8.
    tick(4);
    check("idle_row1", 32'(row_drive), 32'h4);
    tick(4);
    check("idle_row2", 32'(row_drive), 32'h2);
    tick(4);
    check("idle_row3", 32'(row_drive), 32'h1);
    tick(4);
    check("idle_wrap", 32'(row_drive), 32'h8);
    run_quiet(48, nv, rows);
    check("idle_no_valid", 32'(nv), 32'd0);

    // Row 1 / col 2 press, consumer ready.
    pr = 1; pc = 2; mode = 1;
    wait_valid("press44");
    check("press44_data", 32'(key_data), 32'h44);
    check("press44_held", 32'(key_held), 32'd1);
    tick(1);
    check("press44_one_cycle", 32'(key_valid), 32'd0);
    tick(20);
    check("press44_row_frozen", 32'(row_drive), 32'h4);
    check("press44_no_repeat", 32'(key_valid), 32'd0);
    mode = 0;
    wait_release("press44");

    // Same key with backpressure for 20 cycles.
    key_ready = 1'b0;
    mode = 1;
    wait_valid("bp");
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (!(key_valid === 1'b1 && key_data === 8'h44)) stable = 1'b0;
    end
    check("bp_stable", 32'(stable), 32'd1);
    key_ready = 1'b1;
    tick(1);
    check("bp_drop", 32'(key_valid), 32'd0);
    check("bp_data_kept", 32'(key_data), 32'h44);
    mode = 0;
    wait_release("bp");

    // Bounce on row 3 column 0.
    mode = 2;
    run_quiet(64, nv, rows);
    check("bounce_no_valid", 32'(nv), 32'd0);
    check("bounce_scanning", 32'(rows), 32'hF);
    mode = 0;

    // Ghost pattern on row 0.
    mode = 3;
    run_quiet(64, nv, rows);
    check("ghost_no_valid", 32'(nv), 32'd0);
    check("ghost_scanning", 32'(rows), 32'hF);
    mode = 0;

    // Row 3 / col 3 press, then release timing.
    pr = 3; pc = 3; mode = 1;
    wait_valid("press18");
    check("press18_data", 32'(key_data), 32'h18);
    tick(3);
    mode = 0;
    k = 0;
    while (key_held && k < 40) begin tick(1); k++; end
    check("release_window", 32'((k >= 7) && (k <= 10)), 32'd1);
    run_quiet(40, nv, rows);
    check("release_no_second", 32'(nv), 32'd0);

    // Reset in the middle of a debounce.
    pr = 2; pc = 1; mode = 1;
    k = 0;
    while (m_streak != 1 && k < 200) begin tick(1); k++; end
    check("mid_debounce_reached", 32'(m_streak), 32'd1);
    rst = 1'b1;
    mode = 0;
    tick(1);
    check("mid_rst_row", 32'(row_drive), 32'h8);
    check("mid_rst_valid", 32'(key_valid), 32'd0);
    rst = 1'b0;
    run_quiet(64, nv, rows);
    check("mid_rst_no_key", 32'(nv), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
